// File: rtl/processor_pkg.sv
// ----------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the 3-stage core: register-file geometry and the
// opcode constants the issue stage decodes to decide which operands are read
// and whether the instruction writes a destination register.
// No ports (package).
// ----------------------------------------------------------------------------
package processor_pkg;

    localparam int REG_ADDR_BITS = 3;
    localparam int REG_COUNT     = 8;

    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

    // Opcode field encodings used by the issue stage.
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_LOADI  = 4'h5;
    localparam logic [3:0] OP_LOAD   = 4'h6;
    localparam logic [3:0] OP_STORE  = 4'h7;
    localparam logic [3:0] OP_BRANCH = 4'h8;
    localparam logic [3:0] OP_CALL   = 4'h9;
    localparam logic [3:0] OP_RET    = 4'hA;

    // True for opcodes that produce a register result (issue_dest_enable).
    function automatic logic op_writes_dest(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LOADI) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/processor_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register count of in-flight destination writes. Raises stall when an
// issuing instruction reads a register with an outstanding write (unless that
// write is the only one and lands this very cycle, where the bypass covers it)
// or when its destination counter is saturated. sb_error is sticky until reset.
// Ports:
//   clock, reset                 clock / async active-low reset
//   reg_write_enable/addr        final-stage write (retires one pending write)
//   rd0_addr/use, rd1_addr/use   operand reads of the issuing instruction
//   issue_valid/dest_enable/addr issuing instruction and its destination
//   flush                        clears every counter
//   stall                        issue must hold (combinational)
//   sb_error                     sticky counter underflow/overflow flag
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import processor_pkg::*;
#(
    parameter int PENDING_BITS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     reg_write_enable,
    input  logic [REG_ADDR_BITS-1:0] reg_write_addr,
    input  logic [REG_ADDR_BITS-1:0] rd0_addr,
    input  logic                     rd0_use,
    input  logic [REG_ADDR_BITS-1:0] rd1_addr,
    input  logic                     rd1_use,
    input  logic                     issue_valid,
    input  logic                     issue_dest_enable,
    input  logic [REG_ADDR_BITS-1:0] issue_dest_addr,
    input  logic                     flush,
    output logic                     stall,
    output logic                     sb_error
);

    localparam logic [PENDING_BITS-1:0] PEND_MAX  = '1;
    localparam logic [PENDING_BITS-1:0] PEND_ZERO = '0;
    localparam logic [PENDING_BITS-1:0] PEND_ONE  = PENDING_BITS'(1);

    logic [PENDING_BITS-1:0] pend [REG_COUNT];
    logic [PENDING_BITS-1:0] pend0, pend1, pend_dest;
    logic                    haz0, haz1, dest_full;
    logic [REG_COUNT-1:0]    inc_vec, dec_vec;

    assign pend0     = pend[rd0_addr];
    assign pend1     = pend[rd1_addr];
    assign pend_dest = pend[issue_dest_addr];

    // A single outstanding write that retires this cycle is forwarded by the
    // bypass mux, so it is not a hazard.
    assign haz0 = rd0_use && (pend0 != PEND_ZERO) &&
                  !((pend0 == PEND_ONE) && reg_write_enable && (reg_write_addr == rd0_addr));
    assign haz1 = rd1_use && (pend1 != PEND_ZERO) &&
                  !((pend1 == PEND_ONE) && reg_write_enable && (reg_write_addr == rd1_addr));
    assign dest_full = issue_dest_enable && (pend_dest == PEND_MAX);

    assign stall = issue_valid && !flush && (haz0 || haz1 || dest_full);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            inc_vec[r] = issue_valid && issue_dest_enable && !stall &&
                         (issue_dest_addr == reg_addr_t'(r));
            dec_vec[r] = reg_write_enable && (reg_write_addr == reg_addr_t'(r));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) pend[r] <= PEND_ZERO;
            sb_error <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < REG_COUNT; r++) pend[r] <= PEND_ZERO;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10: begin
                        if (pend[r] == PEND_MAX) sb_error <= 1'b1;
                        else                     pend[r]  <= pend[r] + PEND_ONE;
                    end
                    2'b01: begin
                        // Write with no issue record: keep the count at zero.
                        if (pend[r] == PEND_ZERO) sb_error <= 1'b1;
                        else                      pend[r]  <= pend[r] - PEND_ONE;
                    end
                    default: ;  // idle, or issue and retire cancel out
                endcase
            end
        end
    end

endmodule

// File: rtl/processor_regfile.sv
// ----------------------------------------------------------------------------
// processor_regfile
// 8 x WORD_SIZE general register file with two combinational read ports that
// forward the final-stage write in the same cycle, plus the write-pending
// scoreboard that stalls issue on read-after-write hazards.
// Ports:
//   clock, reset                      clock / async active-low reset
//   reg_write_enable/addr/data        final-stage write port
//   rd0_addr/use/data, rd1_addr/use/data  operand read ports (bypassed)
//   issue_valid/dest_enable/dest_addr issuing instruction
//   flush                             drop all pending writes
//   stall, sb_error                   scoreboard outputs
// ----------------------------------------------------------------------------
module processor_regfile
    import processor_pkg::*;
#(
    parameter int WORD_SIZE    = 18,
    parameter int PENDING_BITS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     reg_write_enable,
    input  logic [REG_ADDR_BITS-1:0] reg_write_addr,
    input  logic [WORD_SIZE-1:0]     reg_write_data,
    input  logic [REG_ADDR_BITS-1:0] rd0_addr,
    input  logic                     rd0_use,
    output logic [WORD_SIZE-1:0]     rd0_data,
    input  logic [REG_ADDR_BITS-1:0] rd1_addr,
    input  logic                     rd1_use,
    output logic [WORD_SIZE-1:0]     rd1_data,
    input  logic                     issue_valid,
    input  logic                     issue_dest_enable,
    input  logic [REG_ADDR_BITS-1:0] issue_dest_addr,
    input  logic                     flush,
    output logic                     stall,
    output logic                     sb_error
);

    logic [WORD_SIZE-1:0] regs [REG_COUNT];

    // NOTE: the array is small and must read as zero after reset, so it is
    // built from resettable flops rather than a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
        end else if (reg_write_enable) begin
            regs[reg_write_addr] <= reg_write_data;
        end
    end

    assign rd0_data = (reg_write_enable && (reg_write_addr == rd0_addr)) ? reg_write_data
                                                                         : regs[rd0_addr];
    assign rd1_data = (reg_write_enable && (reg_write_addr == rd1_addr)) ? reg_write_data
                                                                         : regs[rd1_addr];

    regfile_scoreboard #(
        .PENDING_BITS (PENDING_BITS)
    ) u_scoreboard (
        .clock             (clock),
        .reset             (reset),
        .reg_write_enable  (reg_write_enable),
        .reg_write_addr    (reg_write_addr),
        .rd0_addr          (rd0_addr),
        .rd0_use           (rd0_use),
        .rd1_addr          (rd1_addr),
        .rd1_use           (rd1_use),
        .issue_valid       (issue_valid),
        .issue_dest_enable (issue_dest_enable),
        .issue_dest_addr   (issue_dest_addr),
        .flush             (flush),
        .stall             (stall),
        .sb_error          (sb_error)
    );

endmodule
